// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//
// Registered operand front end for the ALU adder. Each accepted beat is
// conditioned for add or subtract (B is inverted for subtract, carry-in is
// the subtract flag). Per-bit propagate and generate vectors are formed, and
// the result is stored in a 2-entry FIFO skid buffer that feeds the
// byte-wide carry-lookahead adder blocks downstream.
//
// Parameters:
//   WIDTH      operand width; must be a non-zero multiple of 8
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat (registered state only)
//   in_a       operand A
//   in_b       operand B
//   in_sub     1 = A - B, 0 = A + B
//   out_valid  head entry valid toward the adder
//   out_ready  adder accepts the head entry
//   out_x      adder operand x (= A)
//   out_y      adder operand y (= B or ~B)
//   out_p      per-bit propagate, x | y
//   out_g      per-bit generate, x & y
//   out_cin    carry into bit 0
//   out_sub    opcode carried alongside for flag logic
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised, the payload must stay stable until that
// transfer occurs. Ready never depends combinationally on valid on the same
// side.
module alu_operand_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_g,
  output logic             out_cin,
  output logic             out_sub
);

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             cin;
    logic             sub;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;

  entry_t     new_entry;
  entry_t     head_entry;
  logic       head_idx;
  logic       push;
  logic       pop;

  // Bitwise conditioning of the incoming beat; no width growth.
  always_comb begin
    new_entry     = '0;
    new_entry.x   = in_a;
    new_entry.y   = in_sub ? ~in_b : in_b;
    new_entry.p   = new_entry.x | new_entry.y;
    new_entry.g   = new_entry.x & new_entry.y;
    new_entry.cin = in_sub;
    new_entry.sub = in_sub;
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // When empty, the read pointer has already moved past the last popped
  // entry. Look one slot back so the outputs keep showing the last popped
  // beat. After reset both slots are zero, so either slot yields zeros.
  assign head_idx   = (count_q == 2'd0) ? ~rd_ptr_q : rd_ptr_q;
  assign head_entry = mem_q[head_idx];

  assign out_x   = head_entry.x;
  assign out_y   = head_entry.y;
  assign out_p   = head_entry.p;
  assign out_g   = head_entry.g;
  assign out_cin = head_entry.cin;
  assign out_sub = head_entry.sub;

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage is reset as well, so the data outputs read zero as soon as
  // reset asserts without waiting for a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage
//
// Directed bench for alu_operand_stage. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_alu_operand_stage;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_x;
  logic [W-1:0] out_y;
  logic [W-1:0] out_p;
  logic [W-1:0] out_g;
  logic         out_cin;
  logic         out_sub;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];

  alu_operand_stage #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_p     (out_p),
    .out_g     (out_g),
    .out_cin   (out_cin),
    .out_sub   (out_sub)
  );

  // Clock and watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit expired before the end of the test");
    $fatal(1, "watchdog");
  end

  // Driver helper
  task automatic drive(input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic s);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_sub   = s;
  endtask

  task automatic test_reset;
    // still in reset here
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
    checks++;
    if (out_x !== '0 || out_y !== '0 || out_p !== '0 || out_g !== '0 ||
        out_cin !== 1'b0 || out_sub !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: x=%h y=%h p=%h g=%h cin=%b sub=%b, want all 0",
               out_x, out_y, out_p, out_g, out_cin, out_sub);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_add;
    @(negedge clock);
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    @(negedge clock);
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_x !== 32'h0000_00FF || out_y !== 32'h0000_0001 ||
        out_p !== 32'h0000_00FF || out_g !== 32'h0000_0001 || out_cin !== 1'b0 ||
        out_sub !== 1'b0) begin
      errors++;
      $display("FAIL add: v=%b x=%h y=%h p=%h g=%h cin=%b sub=%b, want 1 ff 1 ff 1 0 0",
               out_valid, out_x, out_y, out_p, out_g, out_cin, out_sub);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    // empty: last popped beat stays visible
    checks++;
    if (out_valid !== 1'b0 || out_x !== 32'h0000_00FF || out_p !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL add_hold: v=%b x=%h p=%h, want 0 ff ff", out_valid, out_x, out_p);
    end
  endtask

  task automatic test_sub;
    @(negedge clock);
    drive(1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1);
    @(negedge clock);
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_x !== 32'h0000_0005 || out_y !== 32'hFFFF_FFFC ||
        out_p !== 32'hFFFF_FFFD || out_g !== 32'h0000_0004 || out_cin !== 1'b1 ||
        out_sub !== 1'b1) begin
      errors++;
      $display("FAIL sub: v=%b x=%h y=%h p=%h g=%h cin=%b sub=%b, want 1 5 fffffffc fffffffd 4 1 1",
               out_valid, out_x, out_y, out_p, out_g, out_cin, out_sub);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_y !== 32'hFFFF_FFFC || out_sub !== 1'b1) begin
      errors++;
      $display("FAIL sub_hold: v=%b y=%h sub=%b, want 0 fffffffc 1", out_valid, out_y, out_sub);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    @(negedge clock);
    drive(1'b1, 32'd1, 32'd0, 1'b0);
    @(negedge clock);
    drive(1'b1, 32'd2, 32'd0, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_one: in_ready=%b, want 1", in_ready);
    end
    @(negedge clock);
    drive(1'b1, 32'd3, 32'd0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_x !== 32'd1) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b v=%b x=%h, want 0 1 1", in_ready, out_valid, out_x);
    end
    @(negedge clock);
    // beat 3 still offered and must be ignored; head stays stable
    checks++;
    if (in_ready !== 1'b0 || out_x !== 32'd1) begin
      errors++;
      $display("FAIL bp_stable: in_ready=%b x=%h, want 0 1", in_ready, out_x);
    end
    out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_x !== 32'd2) begin
      errors++;
      $display("FAIL bp_pop1: in_ready=%b v=%b x=%h, want 1 1 2", in_ready, out_valid, out_x);
    end
    @(negedge clock);
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_x !== 32'd3) begin
      errors++;
      $display("FAIL bp_pop2: v=%b x=%h, want 1 3", out_valid, out_x);
    end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%b, want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp;
    out_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      if (c >= 1) begin
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_x !== exp || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_%0d: v=%b x=%h rdy=%b, want 1 %h 1", c, out_valid, out_x, in_ready, exp);
        end
      end
      if (c < 8) begin
        drive(1'b1, W'(c), 32'h0000_1000, 1'b0);
        exp_q.push_back(W'(c));
      end else begin
        drive(1'b0, '0, '0, 1'b0);
      end
    end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_end: v=%b left=%0d, want 0 0", out_valid, exp_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_push_pop;
    out_ready = 1'b0;
    @(negedge clock);
    drive(1'b1, 32'h10, 32'h0, 1'b0);
    @(negedge clock);
    drive(1'b1, 32'h20, 32'h0, 1'b0);
    out_ready = 1'b1;
    checks++;
    if (out_x !== 32'h10 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pp_head: v=%b x=%h, want 1 10", out_valid, out_x);
    end
    @(negedge clock);
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_x !== 32'h20 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pp_advance: v=%b x=%h rdy=%b, want 1 20 1", out_valid, out_x, in_ready);
    end
    @(negedge clock);
    out_ready = 1'b0;
    // one pop empties it, so the count stayed at 1
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pp_count: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    @(negedge clock);
    drive(1'b1, 32'h0000_000A, 32'h0000_0003, 1'b1);
    @(negedge clock);
    drive(1'b1, 32'h0000_000B, 32'h0000_0003, 1'b1);
    @(negedge clock);
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_x !== 32'h0000_000A) begin
      errors++;
      $display("FAIL rm_full: in_ready=%b x=%h, want 0 a", in_ready, out_x);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_x !== '0 || out_y !== '0 ||
        out_p !== '0 || out_g !== '0 || out_cin !== 1'b0 || out_sub !== 1'b0) begin
      errors++;
      $display("FAIL rm_async: v=%b rdy=%b x=%h y=%h p=%h g=%h cin=%b sub=%b, want 0 1 and zeros",
               out_valid, in_ready, out_x, out_y, out_p, out_g, out_cin, out_sub);
    end
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 32'h0000_0055, 32'h0, 1'b0);
    out_ready = 1'b1;
    @(negedge clock);
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_x !== 32'h0000_0055 || out_sub !== 1'b0) begin
      errors++;
      $display("FAIL rm_first: v=%b x=%h sub=%b, want 1 55 0", out_valid, out_x, out_sub);
    end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_drain: out_valid=%b, want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_push_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
